display_scan_scheduler: RTL and testbench

//   Time-multiplexes NUM_DIGITS 7-segment digit patterns onto one shared segment bus.

---
 rtl/display_scan_scheduler.sv | 96 +++++++++
 tb/tb_display_scan_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: time-multiplexes NUM_DIGITS segment patterns onto a
// shared bus with a blanking gap at each slot start and a 16-level brightness
// on-window inside every slot. All outputs are registered, one cycle behind the
// phase/digit counters.
module display_scan_scheduler #(
  parameter int          NUM_DIGITS       = 4,
  parameter int          SCAN_DIVIDER     = 6750,
  parameter int          BLANK_CYCLES     = 16,
  parameter logic        DIGIT_ACTIVE_LOW = 1'b1,
  parameter logic [7:0]  SEGMENT_OFF      = 8'hFF
) (
  input  logic                            clkIn,
  input  logic                            resetIn,
  input  logic                            enableIn,
  input  logic [3:0]                      brightnessIn,
  input  logic [NUM_DIGITS-1:0]           digitMaskIn,
  input  logic [8*NUM_DIGITS-1:0]         segmentsIn,
  output logic [7:0]                      segmentEnableOut,
  output logic [NUM_DIGITS-1:0]           digitEnableOut,
  output logic [$clog2(NUM_DIGITS)-1:0]   digitIndexOut,
  output logic                            slotStartOut
);

  localparam int PW = $clog2(SCAN_DIVIDER);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int OW = PW + 5;

  // Value driven on the digit enables when no digit is selected.
  localparam logic [NUM_DIGITS-1:0] DIGITS_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  logic [PW-1:0] phase;
  logic [IW-1:0] digit_idx;
  logic [7:0]    pattern_q;
  logic [3:0]    bright_q;

  logic [7:0]          cur_pattern;
  logic [3:0]          cur_bright;
  logic [OW-1:0]       on_cycles;
  logic [OW-1:0]       phase_w;
  logic                active;
  logic [NUM_DIGITS-1:0] onehot;

  // Slot-effective pattern/brightness: at phase 0 the live inputs are being
  // captured, so use them directly; later in the slot use the latched copy.
  always_comb begin
    cur_pattern = pattern_q;
    cur_bright  = bright_q;
    if (phase == '0) begin
      cur_bright  = brightnessIn;
      cur_pattern = SEGMENT_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_idx == IW'(i)) cur_pattern = segmentsIn[8*i +: 8];
      end
    end
  end

  // On-window decode: digit lit for on_cycles cycles right after the blanking gap.
  always_comb begin
    on_cycles = (OW'(SCAN_DIVIDER - BLANK_CYCLES) * (OW'(cur_bright) + OW'(1))) >> 4;
    phase_w   = OW'(phase);
    active    = (phase_w >= OW'(BLANK_CYCLES)) &&
                (phase_w < OW'(BLANK_CYCLES) + on_cycles) &&
                !digitMaskIn[digit_idx];
    onehot    = NUM_DIGITS'(1) << digit_idx;
  end

  // Scan counters, per-slot latches and registered pin outputs.
  always_ff @(posedge clkIn) begin
    if (resetIn || !enableIn) begin
      phase            <= '0;
      digit_idx        <= '0;
      pattern_q        <= SEGMENT_OFF;
      bright_q         <= '0;
      segmentEnableOut <= SEGMENT_OFF;
      digitEnableOut   <= DIGITS_OFF;
      digitIndexOut    <= '0;
      slotStartOut     <= 1'b0;
    end else begin
      segmentEnableOut <= active ? cur_pattern : SEGMENT_OFF;
      digitEnableOut   <= active ? (DIGITS_OFF ^ onehot) : DIGITS_OFF;
      digitIndexOut    <= digit_idx;
      slotStartOut     <= (phase == '0);
      if (phase == '0) begin
        pattern_q <= cur_pattern;
        bright_q  <= cur_bright;
      end
      if (phase == PW'(SCAN_DIVIDER - 1)) begin
        phase     <= '0;
        digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: directed plus randomized stimulus against a
// slot-counting reference model; expected outputs flow through exp_q.
module tb_display_scan_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  bright;
  logic [3:0]  mask;
  logic [31:0] segs;
  logic [7:0]  seg_out;
  logic [3:0]  dig_out;
  logic [1:0]  idx_out;
  logic        slot_out;

  int total = 0;
  int bad   = 0;

  // Reference model state: n = cycles since the scan (re)started.
  int         n = 0;
  logic [7:0] cap_pat = 8'hFF;
  int         cap_bri = 0;

  // Expected {digit enables, segment bus, index, slot start}.
  logic [14:0] exp_q[$];

  display_scan_scheduler #(
    .NUM_DIGITS(4), .SCAN_DIVIDER(8), .BLANK_CYCLES(2),
    .DIGIT_ACTIVE_LOW(1'b1), .SEGMENT_OFF(8'hFF)
  ) dut (
    .clkIn(clk), .resetIn(rst), .enableIn(en), .brightnessIn(bright),
    .digitMaskIn(mask), .segmentsIn(segs), .segmentEnableOut(seg_out),
    .digitEnableOut(dig_out), .digitIndexOut(idx_out), .slotStartOut(slot_out)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_out(input string tag);
    logic [14:0] e;
    e = exp_q.pop_front();
    total++;
    assert (dig_out === e[14:11]) else begin
      bad++; $error("FAIL %s dig: got %b want %b (t=%0t)", tag, dig_out, e[14:11], $time);
    end
    total++;
    assert (seg_out === e[10:3]) else begin
      bad++; $error("FAIL %s seg: got %h want %h (t=%0t)", tag, seg_out, e[10:3], $time);
    end
    total++;
    assert (idx_out === e[2:1]) else begin
      bad++; $error("FAIL %s idx: got %0d want %0d (t=%0t)", tag, idx_out, e[2:1], $time);
    end
    total++;
    assert (slot_out === e[0]) else begin
      bad++; $error("FAIL %s slot: got %b want %b (t=%0t)", tag, slot_out, e[0], $time);
    end
  endtask

  // One clock: predict from the rules, advance, compare.
  task automatic step(input string tag);
    int ph, di, on;
    logic act;
    logic [3:0] de;
    logic [7:0] se;
    if (rst || !en) begin
      exp_q.push_back({4'hF, 8'hFF, 2'd0, 1'b0});
      n = 0;
    end else begin
      ph = n % 8;
      di = (n / 8) % 4;
      if (ph == 0) begin
        cap_pat = segs[8*di +: 8];
        cap_bri = int'(bright);
      end
      on  = (6 * (cap_bri + 1)) / 16;
      act = (ph >= 2) && (ph < 2 + on) && !mask[di];
      de  = act ? ~(4'b0001 << di) : 4'hF;
      se  = act ? cap_pat : 8'hFF;
      exp_q.push_back({de, se, 2'(di), (ph == 0)});
      n++;
    end
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic run(input int k, input string tag);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  // Advance until the model sits at the given digit/phase (bounded).
  task automatic goto_pos(input int di, input int ph, input string tag);
    int guard;
    guard = 0;
    while (((n / 8) % 4 != di || n % 8 != ph) && guard < 64) begin
      step(tag);
      guard++;
    end
    total++;
    assert (guard < 64) else begin
      bad++; $error("FAIL %s position: got guard %0d want <64", tag, guard);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bright = 4'd15; mask = 4'b0000;
    segs = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset held 3 cycles
    run(3, "reset");
    #0 rst = 1'b0;

    // Full brightness scan over more than one full frame
    run(40, "full");

    // Brightness 7: 3-cycle window
    bright = 4'd7;
    run(34, "bright7");

    // Mask digit 1
    mask = 4'b0010;
    run(34, "mask");
    mask = 4'b0000;

    // Mid-slot change on digit 0 at phase 4
    goto_pos(0, 4, "mid_pre");
    segs[7:0] = 8'hA5;
    run(36, "midslot");

    // Enable drop at phase 5 of digit 2, then re-enable
    goto_pos(2, 5, "dis_pre");
    en = 1'b0;
    step("en_drop");
    en = 1'b1;
    run(12, "reenable");

    // Reset pulse at phase 5 of digit 2
    goto_pos(2, 5, "rst_pre");
    rst = 1'b1;
    step("rst_pulse");
    rst = 1'b0;
    run(12, "after_rst");

    // Brightness 0 boundary
    bright = 4'd0;
    run(16, "bright0");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) segs = $urandom;
      en  = ($urandom_range(0, 29) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step("random");
    end
    rst = 1'b0; en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
